score_blinker: RTL

- Reads the player score held by the score accumulator and shows it on one LED, one blink per point.
- Sits on the output side of the score path: the accumulator writes the score, and this block plays it back.
- The game FSM pulses START at end of round and waits for DONE before clearing the score.

---
 rtl/blink_pkg.sv | 9 +
 rtl/phase_timer.sv | 25 ++
 rtl/score_blinker.sv | 100 ++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared types and defaults for the score display path.
package blink_pkg;

   typedef enum logic [1:0] {IDLE, ON, OFF} blinker_state_t;

   // Must match the score accumulator output width.
   localparam int unsigned SCORE_W_DEFAULT = 4;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that stops at zero; EXP flags the zero count.
module phase_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         CLR,
   input  logic         LD,
   input  logic [W-1:0] D,
   output logic         EXP
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (CLR)
         count <= '0;
      else if (LD)
         count <= D;
      else if (count != '0)
         count <= count - W'(1);
   end

   assign EXP = (count == '0);

endmodule

// File: rtl/score_blinker.sv
// Plays back a latched score as a train of LED blinks, then pulses DONE.
module score_blinker
   import blink_pkg::*;
#(
   parameter int unsigned SCORE_W    = SCORE_W_DEFAULT,
   parameter int unsigned ON_CYCLES  = 25000000,
   parameter int unsigned OFF_CYCLES = 25000000
) (
   input  logic               clk,
   input  logic               CLR,
   input  logic               START,
   input  logic [SCORE_W-1:0] SCORE,
   output logic               LED,
   output logic               BUSY,
   output logic               DONE
);

   localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);

   blinker_state_t     state, state_n;
   logic [SCORE_W-1:0] remain, remain_n;
   logic               led_n, busy_n, done_n;
   logic               tmr_ld, tmr_exp;
   logic [TW-1:0]      tmr_d;

   phase_timer #(.W(TW)) u_timer (
      .clk (clk),
      .CLR (CLR),
      .LD  (tmr_ld),
      .D   (tmr_d),
      .EXP (tmr_exp)
   );

   always_ff @(posedge clk) begin
      if (CLR) begin
         state  <= IDLE;
         remain <= '0;
         LED    <= 1'b0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         state  <= state_n;
         remain <= remain_n;
         LED    <= led_n;
         BUSY   <= busy_n;
         DONE   <= done_n;
      end
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      state_n  = state;
      remain_n = remain;
      tmr_ld   = 1'b0;
      tmr_d    = '0;
      done_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (START) begin
               if (SCORE != '0) begin
                  state_n  = ON;
                  remain_n = SCORE;
                  tmr_ld   = 1'b1;
                  tmr_d    = ON_LD;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         ON: begin
            if (tmr_exp) begin
               state_n = OFF;
               tmr_ld  = 1'b1;
               tmr_d   = OFF_LD;
               if (remain != '0)
                  remain_n = remain - SCORE_W'(1);
            end
         end
         OFF: begin
            if (tmr_exp) begin
               if (remain != '0) begin
                  state_n = ON;
                  tmr_ld  = 1'b1;
                  tmr_d   = ON_LD;
               end else begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      led_n  = (state_n == ON);
      busy_n = (state_n != IDLE);
   end

endmodule
